branch_predictor: RTL and testbench

//  Dynamic branch predictor for the 5-stage pipeline: direct-mapped BTB + saturating-counter BHT.

---
 rtl/branch_predictor_pkg.sv | 44 ++++
 rtl/branch_predictor_if.sv | 29 ++
 rtl/branch_predictor_entry_table.sv | 30 +++
 rtl/branch_predictor.sv | 127 ++++++++++++
 tb/tb_branch_predictor.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types, sizing constants and index/tag/counter helpers for the BTB/BHT branch predictor.
package bp_pkg;

    localparam int PC_W    = 32;
    localparam int INDEX_W = 6;
    localparam int TAG_W   = 8;
    localparam int CNT_W   = 2;
    localparam int ENTRIES = 1 << INDEX_W;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INDEX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    localparam cnt_t CNT_WEAK_NT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam cnt_t CNT_WEAK_T  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam cnt_t CNT_MAX     = {CNT_W{1'b1}};

    typedef struct packed {
        logic valid;
        tag_t tag;
        pc_t  target;
        cnt_t cnt;
    } bp_entry_t;

    localparam bp_entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WEAK_NT};

    function automatic idx_t bp_index(input pc_t pc);
        return pc[INDEX_W+1:2];
    endfunction

    function automatic tag_t bp_tag(input pc_t pc);
        return pc[TAG_W+INDEX_W+1:INDEX_W+2];
    endfunction

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == CNT_MAX) ? c : c + cnt_t'(1);
    endfunction

    function automatic cnt_t sat_dec(input cnt_t c);
        return (c == '0) ? c : c - cnt_t'(1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// IF-stage lookup, ID-stage resolution and statistics signals between pipeline and predictor.
interface branch_predictor_if;
    import bp_pkg::*;

    pc_t         if_pc;
    logic        pred_taken;
    pc_t         pred_next_pc;
    logic        hold_ifid;
    logic        flush_ifid;
    logic        res_valid;
    logic        res_uncond;
    logic        res_taken;
    pc_t         res_target;
    logic        mispredict;
    pc_t         redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_misses;

    modport master (
        output if_pc, hold_ifid, flush_ifid, res_valid, res_uncond, res_taken, res_target,
        input  pred_taken, pred_next_pc, mispredict, redirect_pc, stat_branches, stat_misses
    );

    modport slave (
        input  if_pc, hold_ifid, flush_ifid, res_valid, res_uncond, res_taken, res_target,
        output pred_taken, pred_next_pc, mispredict, redirect_pc, stat_branches, stat_misses
    );

endinterface

// File: rtl/branch_predictor_entry_table.sv
// Direct-mapped BTB/BHT entry array: two async read ports (IF lookup, ID update) and one write port.
module bp_entry_table
    import bp_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  idx_t      lkp_idx_i,
    output bp_entry_t lkp_entry_o,
    input  idx_t      upd_idx_i,
    output bp_entry_t upd_entry_o,
    input  logic      wr_en_i,
    input  bp_entry_t wr_entry_i
);

    bp_entry_t entries_q [ENTRIES];

    assign lkp_entry_o = entries_q[lkp_idx_i];
    assign upd_entry_o = entries_q[upd_idx_i];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= ENTRY_RESET;
            end
        end else if (wr_en_i) begin
            entries_q[upd_idx_i] <= wr_entry_i;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Predict-in-IF branch predictor: table lookup, IF/ID prediction shadow, ID-stage mispredict check.
// Optional event counters are built when BRANCH_PREDICTOR_STATS_EN is defined.
module branch_predictor
    import bp_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    branch_predictor_if.slave        bus
);

    bp_entry_t lkp_entry, upd_entry, wr_entry;
    logic      lkp_hit, upd_hit, upd_en, wr_en;
    logic      pred_taken;
    pc_t       pred_next_pc;

    pc_t  pc_id_q, pc_id_d, ptarget_id_q, ptarget_id_d;
    logic ptaken_id_q, ptaken_id_d, vld_id_q, vld_id_d;

    bp_entry_table u_table (
        .clk         (clk),
        .reset       (reset),
        .lkp_idx_i   (bp_index(bus.if_pc)),
        .lkp_entry_o (lkp_entry),
        .upd_idx_i   (bp_index(pc_id_q)),
        .upd_entry_o (upd_entry),
        .wr_en_i     (wr_en),
        .wr_entry_i  (wr_entry)
    );

    assign lkp_hit      = lkp_entry.valid && (lkp_entry.tag == bp_tag(bus.if_pc));
    assign pred_taken   = lkp_hit && lkp_entry.cnt[CNT_W-1];
    assign pred_next_pc = pred_taken ? lkp_entry.target : bus.if_pc + pc_t'(4);

    assign bus.pred_taken   = pred_taken;
    assign bus.pred_next_pc = pred_next_pc;

    // Flush wins over hold so a squashed slot can never raise a mispredict while stalled.
    always_comb begin
        pc_id_d      = pc_id_q;
        ptaken_id_d  = ptaken_id_q;
        ptarget_id_d = ptarget_id_q;
        vld_id_d     = vld_id_q;
        if (bus.flush_ifid) begin
            vld_id_d    = 1'b0;
            ptaken_id_d = 1'b0;
        end else if (!bus.hold_ifid) begin
            pc_id_d      = bus.if_pc;
            ptaken_id_d  = pred_taken;
            ptarget_id_d = pred_next_pc;
            vld_id_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_id_q      <= '0;
            ptaken_id_q  <= 1'b0;
            ptarget_id_q <= '0;
            vld_id_q     <= 1'b0;
        end else begin
            pc_id_q      <= pc_id_d;
            ptaken_id_q  <= ptaken_id_d;
            ptarget_id_q <= ptarget_id_d;
            vld_id_q     <= vld_id_d;
        end
    end

    assign bus.mispredict = bus.res_valid && vld_id_q && !bus.hold_ifid &&
                            ((ptaken_id_q != bus.res_taken) ||
                             (bus.res_taken && (ptarget_id_q != bus.res_target)));
    assign bus.redirect_pc = bus.res_taken ? bus.res_target : pc_id_q + pc_t'(4);

    assign upd_en  = bus.res_valid && !bus.hold_ifid;
    assign upd_hit = upd_entry.valid && (upd_entry.tag == bp_tag(pc_id_q));

    // Not-taken branches that miss are not allocated, keeping the BTB for branches that jump.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = upd_entry;
        if (upd_en) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (bus.res_uncond) begin
                    wr_entry.cnt = CNT_MAX;
                end else if (bus.res_taken) begin
                    wr_entry.cnt = sat_inc(upd_entry.cnt);
                end else begin
                    wr_entry.cnt = sat_dec(upd_entry.cnt);
                end
                if (bus.res_taken) begin
                    wr_entry.target = bus.res_target;
                end
            end else if (bus.res_taken) begin
                wr_en    = 1'b1;
                wr_entry = '{valid:  1'b1,
                             tag:    bp_tag(pc_id_q),
                             target: bus.res_target,
                             cnt:    bus.res_uncond ? CNT_MAX : CNT_WEAK_T};
            end
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_branches_q, stat_misses_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_branches_q <= '0;
            stat_misses_q   <= '0;
        end else begin
            if (upd_en && (stat_branches_q != 32'hFFFF_FFFF)) begin
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            if (bus.mispredict && (stat_misses_q != 32'hFFFF_FFFF)) begin
                stat_misses_q <= stat_misses_q + 32'd1;
            end
        end
    end

    assign bus.stat_branches = stat_branches_q;
    assign bus.stat_misses   = stat_misses_q;
`else
    assign bus.stat_branches = '0;
    assign bus.stat_misses   = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: allocation, counter training, aliasing,
// stall/flush interaction, pc wrap, statistics and asynchronous reset mid-run.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic reset;
    int   testCount = 0;
    int   failCount = 0;

`ifdef BRANCH_PREDICTOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    branch_predictor_if bus ();

    branch_predictor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] expStat(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic rv, input logic unc,
                                 input logic tk, input logic [31:0] tgt,
                                 input logic hold, input logic flush);
        bus.if_pc      = pc;
        bus.res_valid  = rv;
        bus.res_uncond = unc;
        bus.res_taken  = tk;
        bus.res_target = tgt;
        bus.hold_ifid  = hold;
        bus.flush_ifid = flush;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(32'h0040_0010, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
        checkOutput("rst_next_pc", bus.pred_next_pc, 32'h0040_0014);
        checkOutput("rst_mispredict", 32'(bus.mispredict), 32'd0);
        checkOutput("rst_redirect", bus.redirect_pc, 32'h4);
        checkOutput("rst_stat_br", bus.stat_branches, 32'd0);
        checkOutput("rst_stat_miss", bus.stat_misses, 32'd0);
        #8 reset = 1'b1;
        tick();

        // First taken beq at 0x100: cold miss, then allocated weak-taken.
        applyStimulus(32'h100, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("cold_pred", 32'(bus.pred_taken), 32'd0);
        checkOutput("cold_next", bus.pred_next_pc, 32'h104);
        tick();
        applyStimulus(32'h104, 1, 0, 1, 32'h140, 0, 0);
        checkOutput("alloc_mispredict", 32'(bus.mispredict), 32'd1);
        checkOutput("alloc_redirect", bus.redirect_pc, 32'h140);
        tick();
        applyStimulus(32'h100, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("trained_pred", 32'(bus.pred_taken), 32'd1);
        checkOutput("trained_next", bus.pred_next_pc, 32'h140);
        tick();

        // Not taken: 10 -> 01 with a mispredict, then 01 -> 00, then stays at 00.
        applyStimulus(32'h140, 1, 0, 0, 32'h0, 0, 0);
        checkOutput("nt1_mispredict", 32'(bus.mispredict), 32'd1);
        checkOutput("nt1_redirect", bus.redirect_pc, 32'h104);
        tick();
        applyStimulus(32'h100, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("nt1_pred", 32'(bus.pred_taken), 32'd0);
        checkOutput("nt1_next", bus.pred_next_pc, 32'h104);
        tick();
        applyStimulus(32'h104, 1, 0, 0, 32'h0, 0, 0);
        checkOutput("nt2_mispredict", 32'(bus.mispredict), 32'd0);
        tick();
        applyStimulus(32'h100, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("nt2_pred", 32'(bus.pred_taken), 32'd0);
        tick();
        applyStimulus(32'h104, 1, 0, 0, 32'h0, 0, 0);
        checkOutput("nt3_mispredict", 32'(bus.mispredict), 32'd0);
        tick();
        applyStimulus(32'h100, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("sat_low_pred", 32'(bus.pred_taken), 32'd0);
        tick();

        // Unconditional jump on a hit forces the counter to strongly taken with new target.
        applyStimulus(32'h180, 1, 1, 1, 32'h180, 0, 0);
        checkOutput("jump_mispredict", 32'(bus.mispredict), 32'd1);
        checkOutput("jump_redirect", bus.redirect_pc, 32'h180);
        tick();
        applyStimulus(32'h100, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("jump_pred", 32'(bus.pred_taken), 32'd1);
        checkOutput("jump_next", bus.pred_next_pc, 32'h180);
        applyStimulus(32'h200, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("alias_pred", 32'(bus.pred_taken), 32'd0);
        checkOutput("alias_next", bus.pred_next_pc, 32'h204);
        applyStimulus(32'h100, 0, 0, 0, 32'h0, 0, 0);
        tick();

        // Stall for three edges with a resolution pending: no mispredict, no update.
        applyStimulus(32'h104, 1, 0, 0, 32'h0, 1, 0);
        checkOutput("hold_mispredict", 32'(bus.mispredict), 32'd0);
        tick();
        tick();
        tick();
        applyStimulus(32'h100, 1, 0, 0, 32'h0, 0, 0);
        checkOutput("release_mispredict", 32'(bus.mispredict), 32'd1);
        checkOutput("release_redirect", bus.redirect_pc, 32'h104);
        checkOutput("same_cycle_pred", 32'(bus.pred_taken), 32'd1);
        tick();
        applyStimulus(32'h100, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("hold_one_update", 32'(bus.pred_taken), 32'd1);
        checkOutput("hold_one_next", bus.pred_next_pc, 32'h180);

        // Flush together with hold: the slot is invalidated, so no mispredict next cycle.
        applyStimulus(32'h104, 0, 0, 0, 32'h0, 1, 1);
        tick();
        applyStimulus(32'h100, 1, 0, 0, 32'h0, 0, 0);
        checkOutput("flush_mispredict", 32'(bus.mispredict), 32'd0);
        checkOutput("flush_redirect", bus.redirect_pc, 32'h104);
        checkOutput("flush_same_cycle", 32'(bus.pred_taken), 32'd1);
        tick();
        applyStimulus(32'h100, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("flush_update_pred", 32'(bus.pred_taken), 32'd0);
        checkOutput("stat_br_7", bus.stat_branches, expStat(7));
        checkOutput("stat_miss_4", bus.stat_misses, expStat(4));

        applyStimulus(32'hFFFF_FFFC, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("wrap_pred", 32'(bus.pred_taken), 32'd0);
        checkOutput("wrap_next", bus.pred_next_pc, 32'h0);
        applyStimulus(32'h100, 0, 0, 0, 32'h0, 0, 0);
        tick();

        // Retrain to taken, then pull reset between edges with a mispredict pending.
        applyStimulus(32'h104, 1, 0, 1, 32'h140, 0, 0);
        checkOutput("retrain_mispredict", 32'(bus.mispredict), 32'd1);
        tick();
        applyStimulus(32'h100, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("retrain_pred", 32'(bus.pred_taken), 32'd1);
        checkOutput("stat_br_8", bus.stat_branches, expStat(8));
        checkOutput("stat_miss_5", bus.stat_misses, expStat(5));
        tick();
        applyStimulus(32'h100, 1, 0, 0, 32'h0, 0, 0);
        checkOutput("pre_reset_mispredict", 32'(bus.mispredict), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("midrst_pred", 32'(bus.pred_taken), 32'd0);
        checkOutput("midrst_next", bus.pred_next_pc, 32'h104);
        checkOutput("midrst_mispredict", 32'(bus.mispredict), 32'd0);
        checkOutput("midrst_redirect", bus.redirect_pc, 32'h4);
        checkOutput("midrst_stat_br", bus.stat_branches, 32'd0);
        checkOutput("midrst_stat_miss", bus.stat_misses, 32'd0);
        bus.res_valid = 1'b0;
        #1 reset = 1'b1;
        tick();
        applyStimulus(32'h100, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("post_rst_pred", 32'(bus.pred_taken), 32'd0);
        checkOutput("post_rst_stat_br", bus.stat_branches, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
